// File: rtl/knn_pkg.sv
// Types and width helpers shared by the KNN distance engine and the k-nearest sorter.
package knn_pkg;

    typedef enum logic {
        MODE_MANHATTAN = 1'b0,
        MODE_SQ_EUCLID = 1'b1
    } knn_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } knn_state_e;

    // Accumulator wide enough that summing every element's term can never wrap.
    function automatic int knn_acc_width(input int w, input int elems, input bit sq_en);
        return (sq_en ? 2 * w : w) + $clog2(elems);
    endfunction

    function automatic int knn_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/knn_lane_term.sv
// One lane of the distance engine: combinational |a-b|, optionally squared.
module knn_lane_term
    import knn_pkg::*;
#(
    parameter int W     = 32,
    parameter bit SQ_EN = 1'b0,
    parameter int TW    = SQ_EN ? 2 * W : W
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  knn_mode_e     mode,
    output logic [TW-1:0] term
);

    logic [W-1:0] diff;

    assign diff = (a >= b) ? (a - b) : (b - a);

    generate
        if (SQ_EN) begin : g_sq
            logic [TW-1:0] wide;
            assign wide = TW'(diff);
            assign term = (mode == MODE_SQ_EUCLID) ? wide * wide : wide;
        end else begin : g_abs
            knn_mode_e unused_mode;
            assign unused_mode = mode;
            assign term        = TW'(diff);
        end
    endgenerate

endmodule

// File: rtl/knn_distance_engine.sv
// Streaming multi-lane Manhattan / squared-Euclidean distance engine for the KNN system.
// Define KNN_DIST_SQ_EN to build the squared-Euclidean multipliers and honour 'mode'.
module knn_distance_engine
    import knn_pkg::*;
#(
    parameter int M      = 5,
    parameter int N      = 10,
    parameter int W      = 32,
    parameter int TYPE_W = 2,
    parameter int LANES  = 2,
    parameter int DIST_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [TYPE_W-1:0]   training_data_type,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*W-1:0]  training_data,
    input  logic [LANES*W-1:0]  input_data,
    output logic [DIST_W-1:0]   distance,
    output logic [TYPE_W-1:0]   data_type,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                saturated,
    output logic                busy
);

`ifdef KNN_DIST_SQ_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    localparam int ELEMS = M * N;
    localparam int BEATS = ELEMS / LANES;
    localparam int ACC_W = knn_acc_width(W, ELEMS, SQ_EN);
    localparam int CNT_W = knn_cnt_width(BEATS);
    localparam int TW    = SQ_EN ? 2 * W : W;

    generate
        if ((ELEMS % LANES) != 0) begin : g_bad_lanes
            $error("knn_distance_engine: M*N must be a multiple of LANES");
        end
    endgenerate

    knn_state_e        state, next_state;
    logic [CNT_W-1:0]  beat_cnt;
    logic              drain_wait;
    logic              start_ok;
    knn_mode_e         mode_q;
    logic [TYPE_W-1:0] type_q;
    logic              s1_valid;
    logic [ACC_W-1:0]  s1_sum;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  lane_sum;
    logic [TW-1:0]     lane_terms [LANES];

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            knn_lane_term #(.W(W), .SQ_EN(SQ_EN)) u_term (
                .a    (training_data[i*W +: W]),
                .b    (input_data[i*W +: W]),
                .mode (mode_q),
                .term (lane_terms[i])
            );
        end
    endgenerate

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + ACC_W'(lane_terms[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        start_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (beat_cnt == CNT_W'(BEATS - 1))) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_wait) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Stage 1 captures the lane sum on the accepting edge; stage 2 folds it into acc one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            drain_wait <= 1'b0;
            mode_q     <= MODE_MANHATTAN;
            type_q     <= '0;
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            acc        <= '0;
        end else begin
            drain_wait <= (state == DRAIN);
            s1_valid   <= in_valid & in_ready;
            if (in_valid & in_ready) begin
                s1_sum   <= lane_sum;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (start_ok) begin
                mode_q   <= knn_mode_e'(mode);
                type_q   <= training_data_type;
                beat_cnt <= '0;
                acc      <= '0;
            end else if (s1_valid) begin
                acc <= acc + s1_sum;
            end
        end
    end

    assign data_type = type_q;

    generate
        if (ACC_W > DIST_W) begin : g_clip
            assign saturated = |acc[ACC_W-1:DIST_W];
            assign distance  = saturated ? {DIST_W{1'b1}} : acc[DIST_W-1:0];
        end else begin : g_fit
            assign saturated = 1'b0;
            assign distance  = DIST_W'(acc);
        end
    endgenerate

endmodule

// File: tb/tb_knn_distance_engine.sv
// Self-checking bench for knn_distance_engine: directed test-plan cases plus randomized runs
// against an arithmetic reference model; a second W=16/DIST_W=16 instance covers saturation.
`timescale 1ns/1ps
module tb_knn_distance_engine;

    localparam int ELEMS = 50;
    localparam int BEATS = 25;
`ifdef KNN_DIST_SQ_EN
    localparam bit SQ_BUILT = 1'b1;
`else
    localparam bit SQ_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  training_data_type = 2'd0;
    logic [63:0] training_data = '0;
    logic [63:0] input_data = '0;
    logic [31:0] training_data_s = '0;
    logic [31:0] input_data_s = '0;

    logic        in_ready, out_valid, saturated, busy;
    logic [31:0] distance;
    logic [1:0]  data_type;
    logic        in_ready_s, out_valid_s, saturated_s, busy_s;
    logic [15:0] distance_s;
    logic [1:0]  data_type_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] vec_a [ELEMS];
    logic [31:0] vec_b [ELEMS];

    knn_distance_engine dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .training_data_type(training_data_type),
        .in_valid(in_valid), .in_ready(in_ready),
        .training_data(training_data), .input_data(input_data),
        .distance(distance), .data_type(data_type), .out_valid(out_valid),
        .out_ready(out_ready), .saturated(saturated), .busy(busy)
    );

    knn_distance_engine #(.W(16), .DIST_W(16)) dut_s (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .training_data_type(training_data_type),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .training_data(training_data_s), .input_data(input_data_s),
        .distance(distance_s), .data_type(data_type_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .saturated(saturated_s), .busy(busy_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: sum over all elements of |a-b| or (a-b)^2, in wide plain arithmetic.
    function automatic logic [127:0] model_sum(input bit m);
        logic [127:0] s, a, b, d;
        s = '0;
        for (int i = 0; i < ELEMS; i++) begin
            a = 128'(vec_a[i]);
            b = 128'(vec_b[i]);
            d = (a > b) ? a - b : b - a;
            s = s + ((m && SQ_BUILT) ? d * d : d);
        end
        return s;
    endfunction

    function automatic logic [31:0] model_dist(input logic [127:0] s);
        return (s > 128'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    task automatic set_beat(input int idx);
        training_data   = {vec_a[2*idx+1], vec_a[2*idx]};
        input_data      = {vec_b[2*idx+1], vec_b[2*idx]};
        training_data_s = {vec_a[2*idx+1][15:0], vec_a[2*idx][15:0]};
        input_data_s    = {vec_b[2*idx+1][15:0], vec_b[2*idx][15:0]};
    endtask

    task automatic junk_bus();
        training_data   = {$urandom, $urandom};
        input_data      = {$urandom, $urandom};
        training_data_s = $urandom;
        input_data_s    = $urandom;
    endtask

    // Start a run, stream all beats and return the edges from last accept to out_valid (-1 on timeout).
    task automatic apply_stimulus(input bit m, input logic [1:0] t, input logic [1:0] t_mid,
                                  input bit toggle, input bit noise_start, output int lat);
        int  idx;
        int  guard;
        int  ef;
        bit  taken;
        idx = 0;
        guard = 0;
        ef = 0;
        start = 1'b1;
        mode = m;
        training_data_type = t;
        in_valid = 1'b1;
        junk_bus();
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < BEATS && guard < 400) begin
            in_valid = toggle ? (guard % 2 == 1) : 1'b1;
            if (in_valid) set_beat(idx);
            else junk_bus();
            mode = ~m;
            training_data_type = t_mid;
            start = noise_start && (guard % 5 == 2);
            taken = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (taken) begin
                idx++;
                ef = cyc;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        lat = -1;
        if (idx == BEATS) begin
            for (int k = 0; k < 10 && lat < 0; k++) begin
                if (out_valid) lat = cyc - ef;
                else begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic finish_run();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
        checks++; if (distance !== 32'd0) begin failures++; $display("[TB] FAIL reset_distance: got %0d expected 0", distance); end
        checks++; if (data_type !== 2'd0) begin failures++; $display("[TB] FAIL reset_data_type: got %0d expected 0", data_type); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (saturated !== 1'b0) begin failures++; $display("[TB] FAIL reset_saturated: got %0b expected 0", saturated); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_manhattan_ones();
        int lat;
        for (int i = 0; i < ELEMS; i++) begin vec_a[i] = 32'd1; vec_b[i] = 32'd0; end
        apply_stimulus(1'b0, 2'd2, 2'd1, 1'b0, 1'b0, lat);
        checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL ones_latency: got %0d expected 2", lat); end
        checks++; if (distance !== 32'd50) begin failures++; $display("[TB] FAIL ones_distance: got %0d expected 50", distance); end
        checks++; if (saturated !== 1'b0) begin failures++; $display("[TB] FAIL ones_saturated: got %0b expected 0", saturated); end
        checks++; if (data_type !== 2'd2) begin failures++; $display("[TB] FAIL ones_data_type: got %0d expected 2", data_type); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL ones_busy: got %0b expected 1", busy); end
        finish_run();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL ones_out_valid_drop: got %0b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ones_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_squared();
        int lat;
        logic [31:0] tr [3];
        logic [31:0] ip [3];
        logic [31:0] ex [3];
        tr[0] = 32'd1; ip[0] = 32'd0; ex[0] = 32'd50;
        tr[1] = 32'd3; ip[1] = 32'd0; ex[1] = SQ_BUILT ? 32'd450 : 32'd150;
        tr[2] = 32'd0; ip[2] = 32'd7; ex[2] = SQ_BUILT ? 32'd2450 : 32'd350;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < ELEMS; i++) begin vec_a[i] = tr[c]; vec_b[i] = ip[c]; end
            apply_stimulus(1'b1, 2'd1, 2'd0, 1'b0, 1'b0, lat);
            checks++; if (distance !== ex[c]) begin failures++; $display("[TB] FAIL squared_distance case %0d: got %0d expected %0d", c, distance, ex[c]); end
            checks++; if (saturated !== 1'b0) begin failures++; $display("[TB] FAIL squared_saturated case %0d: got %0b expected 0", c, saturated); end
            finish_run();
        end
    endtask

    task automatic test_saturate();
        int lat;
        for (int i = 0; i < ELEMS; i++) begin vec_a[i] = 32'd65535; vec_b[i] = 32'd0; end
        apply_stimulus(1'b0, 2'd0, 2'd3, 1'b0, 1'b0, lat);
        checks++; if (out_valid_s !== 1'b1) begin failures++; $display("[TB] FAIL sat_out_valid: got %0b expected 1", out_valid_s); end
        checks++; if (distance_s !== 16'hFFFF) begin failures++; $display("[TB] FAIL sat_distance: got %0d expected 65535", distance_s); end
        checks++; if (saturated_s !== 1'b1) begin failures++; $display("[TB] FAIL sat_flag: got %0b expected 1", saturated_s); end
        checks++; if (distance !== 32'd3276750) begin failures++; $display("[TB] FAIL wide_no_sat_distance: got %0d expected 3276750", distance); end
        finish_run();
    endtask

    task automatic test_random_stall();
        int lat;
        bit m;
        logic [1:0] t;
        logic [127:0] s;
        logic [31:0] exp_d;
        bit exp_sat;
        for (int run = 0; run < 6; run++) begin
            m = $urandom_range(0, 1);
            t = 2'($urandom_range(0, 3));
            for (int i = 0; i < ELEMS; i++) begin
                vec_a[i] = (run % 2 == 0) ? $urandom_range(0, 4000) : $urandom;
                vec_b[i] = (run % 2 == 0) ? $urandom_range(0, 4000) : $urandom;
            end
            s = model_sum(m);
            exp_d = model_dist(s);
            exp_sat = (s > 128'h0000_0000_FFFF_FFFF);
            apply_stimulus(m, t, ~t, 1'b1, 1'b1, lat);
            checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL rand_latency run %0d: got %0d expected 2", run, lat); end
            checks++; if (distance !== exp_d) begin failures++; $display("[TB] FAIL rand_distance run %0d: got %0d expected %0d", run, distance, exp_d); end
            checks++; if (saturated !== exp_sat) begin failures++; $display("[TB] FAIL rand_saturated run %0d: got %0b expected %0b", run, saturated, exp_sat); end
            checks++; if (data_type !== t) begin failures++; $display("[TB] FAIL rand_data_type run %0d: got %0d expected %0d", run, data_type, t); end
            for (int k = 0; k < 10; k++) begin
                start = (k % 3 == 1);
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b1 || distance !== exp_d) begin
                    failures++;
                    $display("[TB] FAIL stall_hold run %0d cycle %0d: got valid=%0b dist=%0d expected valid=1 dist=%0d", run, k, out_valid, distance, exp_d);
                end
            end
            start = 1'b1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            out_ready = 1'b0;
            checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL handshake_start_ignored run %0d: got busy=%0b expected 0", run, busy); end
        end
    endtask

    task automatic test_abort();
        int lat;
        for (int i = 0; i < ELEMS; i++) begin vec_a[i] = $urandom; vec_b[i] = $urandom; end
        start = 1'b1; mode = 1'b0; training_data_type = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            in_valid = 1'b1;
            set_beat(j);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %0b expected 0", busy); end
        checks++; if (distance !== 32'd0 || data_type !== 2'd0) begin failures++; $display("[TB] FAIL abort_cleared: got dist=%0d type=%0d expected 0/0", distance, data_type); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < ELEMS; i++) begin
            vec_b[i] = $urandom_range(2, 1000000);
            vec_a[i] = (i % 2 == 0) ? vec_b[i] + 32'd2 : vec_b[i] - 32'd2;
        end
        apply_stimulus(1'b0, 2'd1, 2'd2, 1'b0, 1'b0, lat);
        checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL abort_rerun_latency: got %0d expected 2", lat); end
        checks++; if (distance !== 32'd100) begin failures++; $display("[TB] FAIL abort_rerun_distance: got %0d expected 100", distance); end
        checks++; if (saturated !== 1'b0) begin failures++; $display("[TB] FAIL abort_rerun_saturated: got %0b expected 0", saturated); end
        finish_run();
    endtask

    task automatic test_type_latch();
        int lat;
        logic [31:0] exp_d;
        for (int i = 0; i < ELEMS; i++) begin vec_a[i] = $urandom_range(0, 500); vec_b[i] = $urandom_range(0, 500); end
        exp_d = model_dist(model_sum(1'b0));
        apply_stimulus(1'b0, 2'd3, 2'd1, 1'b1, 1'b0, lat);
        checks++; if (data_type !== 2'd3) begin failures++; $display("[TB] FAIL type_latched: got %0d expected 3", data_type); end
        checks++; if (distance !== exp_d) begin failures++; $display("[TB] FAIL type_run_distance: got %0d expected %0d", distance, exp_d); end
        finish_run();
    endtask

    initial begin
        test_reset();
        test_manhattan_ones();
        test_squared();
        test_saturate();
        test_random_stall();
        test_abort();
        test_type_latch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/knn_distance_engine.md
# knn_distance_engine

Streaming, multi-lane distance engine for the KNN system; the parametrised successor of the single-mode `distance_calculator`. It accepts a training vector and an input vector of M×N elements, LANES element pairs per beat, over a valid/ready stream. It accumulates either Manhattan or squared-Euclidean distance and returns the distance tagged with the training type. It sits between the training-memory reader and the k-nearest sorter.

## Interface
- `M`, 5: rows per sample
- `N`, 10: columns per sample
- `W`, 32: element width, unsigned
- `TYPE_W`, 2: class-label width
- `LANES`, 2: element pairs per beat; M*N % LANES != 0 is an elaboration error
- `DIST_W`, 32: output distance width
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle request to begin a comparison; sampled only in IDLE
- `mode` in 1: 0 = Manhattan, 1 = squared Euclidean; latched on accepted `start`
- `training_data_type` in TYPE_W: label, latched on accepted `start`
- `in_valid` in 1: beat valid
- `in_ready` out 1: beat accepted when `in_valid & in_ready` (replaces `data_request`)
- `training_data` in LANES*W: lane i at bits [i*W +: W]
- `input_data` in LANES*W: same packing
- `distance` out DIST_W: result, stable while `out_valid`
- `data_type` out TYPE_W: latched label
- `out_valid` out 1: result available (replaces `done`)
- `out_ready` in 1: consumer accepts result
- `saturated` out 1: accumulator exceeded 2^DIST_W−1; valid with `out_valid`
- `busy` out 1: state != IDLE

## Operation
- BEATS = M*N/LANES.
- ACC_W = 2W + clog2(M*N) internally. Inputs are unsigned.
- FSM states:
  - IDLE: `in_ready`=0. On `start`: latch mode/type, clear accumulator, beat counter and sticky sat, go to ACCUM.
  - ACCUM: `in_ready`=1. Each accepted beat increments the counter. On the beat with counter = BEATS−1, go to DRAIN. `in_valid`=0 inserts a bubble and contributes nothing.
  - DRAIN: `in_ready`=0. Waits 2 cycles for pipeline flush, then goes to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- Lane term: d = |a−b|, W bits. The term is d in Manhattan mode, and d*d (2W bits) in squared mode.
- Lane terms are summed and added to the accumulator.
- `distance` = min(acc, 2^DIST_W−1); `saturated` = acc > 2^DIST_W−1.
- Boundary behaviour:
  - `start` outside IDLE is ignored, including in DONE. A `start` in the same cycle as the DONE→IDLE handshake is also ignored.
  - `start` and a beat in the same cycle: the beat is not accepted, because `in_ready`=0 in IDLE.
  - `mode`/`training_data_type` changes after `start` have no effect on the run in progress.
  - `rst` at any time returns the FSM to IDLE, clears all state and aborts any in-flight comparison.

## Timing
- Reset values: `in_ready`=0, `distance`=0, `data_type`=0, `out_valid`=0, `saturated`=0, `busy`=0.
- `start` high at edge E0 → `in_ready`=1 after E0.
- Two-stage pipeline:
  - Stage 1 (lane terms) registers on the accepting edge.
  - Stage 2 (accumulate) registers on the next edge.
- Latency: with the final beat accepted at edge Ef, `out_valid` rises after edge Ef+2.
- Minimum run is BEATS+3 cycles from `start`, plus 1 cycle for the handshake.
- `out_valid`, `distance` and `data_type` hold indefinitely until `out_ready` is high on an edge. `out_valid` falls after that edge.

## Configuration
- `KNN_DIST_SQ_EN` defined: squared-Euclidean path (LANES W×W multipliers) is built, and `mode` is honoured.
- `KNN_DIST_SQ_EN` undefined: no multipliers are built, `mode` is ignored (always Manhattan), and ACC_W reduces to W + clog2(M*N).

## Structure
- Package `knn_pkg`:
  - mode enum (MODE_MANHATTAN, MODE_SQ_EUCLID)
  - FSM state enum (IDLE, ACCUM, DRAIN, DONE)
  - ACC_W/beat-counter width derivation functions
  - Shared with the sorter.
- Sub-module `knn_lane_term`: one instance per lane, combinational |a−b| and optional square. The stage-1 register lives in the parent.

## Test plan
- M=5, N=10, LANES=2, all train=1, input=0, Manhattan, `in_valid` held high → distance=50, `saturated`=0, `out_valid` after edge Ef+2.
- Same data and run, squared mode → distance=50. With train=3, input=0 → distance=450. With train=0, input=7 → distance=2450.
- W=16, DIST_W=16, train=65535, input=0, Manhattan → distance=65535, `saturated`=1.
- Random data, `in_valid` toggled every other cycle, `out_ready` low for 10 cycles → result matches the reference model. Outputs hold through the stall. `start` pulses during ACCUM/DONE are ignored.
- `rst` asserted after 10 of 25 beats, then a fresh run with all diffs=2 in Manhattan mode → distance=100, no residue from the aborted run.
- `training_data_type`=3 at `start`, changed to 1 mid-run → `data_type`=3.
